// File: rtl/i2c_ball_slave_if.sv
// ---------------------------------------------------------------------------
// i2c_ball_slave_if
// Parallel ball-state bus produced by the I2C ball receiver.
//   ball_y[9:0]          received ball Y position
//   ball_vy[7:0]         received ball Y velocity
//   gravity_counter[1:0] received gravity phase
//   safe_speed[7:0]      received speed limit
//   is_ball_moving_left  received direction flag
//   rx_valid             1-cycle strobe: a new packet was just committed
//   busy                 transfer in progress (START seen, no STOP yet)
//   led[15:0]            debug {frame_err_cnt, 1'b0, state, byte_cnt}
// Modports: slave = the receiver driving the bus, master = the consumer.
// ---------------------------------------------------------------------------
interface i2c_ball_slave_if;
    logic [9:0]  ball_y;
    logic [7:0]  ball_vy;
    logic [1:0]  gravity_counter;
    logic [7:0]  safe_speed;
    logic        is_ball_moving_left;
    logic        rx_valid;
    logic        busy;
    logic [15:0] led;

    modport slave (
        output ball_y, ball_vy, gravity_counter, safe_speed,
               is_ball_moving_left, rx_valid, busy, led
    );

    modport master (
        input  ball_y, ball_vy, gravity_counter, safe_speed,
               is_ball_moving_left, rx_valid, busy, led
    );
endinterface

// File: rtl/i2c_ball_slave.sv
// ---------------------------------------------------------------------------
// i2c_ball_slave
// I2C target that receives the 4-byte ball-state packet from the opposite
// board and presents it as registered fields with a one-cycle valid strobe.
// SCL is input only (no clock stretching); SDA is open-drain (0 or z).
// Ports:
//   clk    system clock, at least 20x the SCL rate
//   reset  synchronous, active-high
//   SCL    I2C clock from the master
//   SDA    I2C data, driven only low or released
//   o_pkt  ball-state output bus (slave modport of i2c_ball_slave_if)
// Wire packing, MSB first: byte0 = ball_y[7:0],
//   byte1 = {3'b0, is_left, gravity[1:0], ball_y[9:8]}, byte2 = ball_vy,
//   byte3 = safe_speed.
// ---------------------------------------------------------------------------
module i2c_ball_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h2A,
    parameter int         NUM_BYTES  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SCL,
    inout  wire              SDA,
    i2c_ball_slave_if.slave  o_pkt
);
    localparam logic [3:0] NB = 4'(NUM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_DATA     = 3'd3,
        S_DATA_ACK = 3'd4,
        S_IGNORE   = 3'd5
    } state_t;

    state_t      r_state, w_state_next;

    // Two synchronizer stages plus one history stage per pin; the bus idles
    // high, so those flops come out of reset high to avoid phantom edges.
    logic [1:0]  r_scl_sync, r_sda_sync;
    logic        r_scl_hist, r_sda_hist;
    logic [6:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic [3:0]  r_byte_cnt;
    logic        r_sda_oe;
    logic        r_ack_done;
    logic [7:0]  r_frame_err_cnt;
    // Shadow copy of the packet being received; only the used bits are kept.
    logic [7:0]  r_sh_y_lo, r_sh_vy, r_sh_spd;
    logic [4:0]  r_sh_hi;
    logic [9:0]  r_ball_y;
    logic [7:0]  r_ball_vy, r_safe_speed;
    logic [1:0]  r_gravity;
    logic        r_is_left;
    logic        r_rx_valid;

    logic        w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]  w_byte;

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise = w_scl & ~r_scl_hist;
    assign w_scl_fall = ~w_scl & r_scl_hist;
    assign w_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
    assign w_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;
    // Byte as it stands once the current SCL rise is shifted in.
    assign w_byte     = {r_shift, w_sda};

    assign SDA = r_sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = S_ADDR;
        end else if (w_stop) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_ADDR:
                    if (w_scl_rise && r_bit_cnt == 3'd7)
                        w_state_next = (w_byte == {SLAVE_ADDR, 1'b0}) ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK:
                    if (w_scl_fall && r_sda_oe) w_state_next = S_DATA;
                S_DATA:
                    if (w_scl_rise && r_bit_cnt == 3'd7) w_state_next = S_DATA_ACK;
                S_DATA_ACK:
                    if (r_byte_cnt > NB)               w_state_next = S_IGNORE;
                    else if (w_scl_fall && r_sda_oe)  w_state_next = S_DATA;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_sync      <= 2'b11;
            r_sda_sync      <= 2'b11;
            r_scl_hist      <= 1'b1;
            r_sda_hist      <= 1'b1;
            r_shift         <= '0;
            r_bit_cnt       <= '0;
            r_byte_cnt      <= '0;
            r_sda_oe        <= 1'b0;
            r_ack_done      <= 1'b0;
            r_frame_err_cnt <= '0;
            r_sh_y_lo       <= '0;
            r_sh_hi         <= '0;
            r_sh_vy         <= '0;
            r_sh_spd        <= '0;
            r_ball_y        <= '0;
            r_ball_vy       <= '0;
            r_safe_speed    <= '0;
            r_gravity       <= '0;
            r_is_left       <= 1'b0;
            r_rx_valid      <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[0], SCL};
            r_sda_sync <= {r_sda_sync[0], SDA};
            r_scl_hist <= w_scl;
            r_sda_hist <= w_sda;
            r_rx_valid <= 1'b0;

            if (w_start || w_stop) begin
                // A STOP only commits a packet whose last ACK clock finished;
                // any other non-empty transfer is counted as a framing error.
                if (w_stop) begin
                    if (r_byte_cnt == NB && r_ack_done) begin
                        r_ball_y     <= {r_sh_hi[1:0], r_sh_y_lo};
                        r_gravity    <= r_sh_hi[3:2];
                        r_is_left    <= r_sh_hi[4];
                        r_ball_vy    <= r_sh_vy;
                        r_safe_speed <= r_sh_spd;
                        r_rx_valid   <= 1'b1;
                    end else if (r_byte_cnt != 4'd0 && r_frame_err_cnt != 8'hFF) begin
                        r_frame_err_cnt <= r_frame_err_cnt + 8'd1;
                    end
                end
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
                r_sda_oe   <= 1'b0;
                r_ack_done <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_DATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7 && r_state == S_DATA) begin
                                case (r_byte_cnt)
                                    4'd0:    r_sh_y_lo <= w_byte;
                                    4'd1:    r_sh_hi   <= w_byte[4:0];
                                    4'd2:    r_sh_vy   <= w_byte;
                                    4'd3:    r_sh_spd  <= w_byte;
                                    default: ;
                                endcase
                                r_byte_cnt <= r_byte_cnt + 4'd1;
                                r_ack_done <= 1'b0;
                            end
                        end
                    end
                    // First SCL fall after bit 8 starts driving the ACK low,
                    // the next fall releases it.
                    S_ADDR_ACK: if (w_scl_fall) r_sda_oe <= ~r_sda_oe;
                    S_DATA_ACK: begin
                        if (w_scl_fall && r_byte_cnt <= NB) begin
                            r_sda_oe <= ~r_sda_oe;
                            if (r_sda_oe) r_ack_done <= 1'b1;
                        end
                    end
                    default: r_sda_oe <= 1'b0;
                endcase
            end
        end
    end

    assign o_pkt.ball_y              = r_ball_y;
    assign o_pkt.ball_vy             = r_ball_vy;
    assign o_pkt.gravity_counter     = r_gravity;
    assign o_pkt.safe_speed          = r_safe_speed;
    assign o_pkt.is_ball_moving_left = r_is_left;
    assign o_pkt.rx_valid            = r_rx_valid;
    assign o_pkt.busy                = (r_state != S_IDLE);
    assign o_pkt.led                 = {r_frame_err_cnt, 1'b0, r_state, r_byte_cnt};
endmodule
